// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared backend types for the cache request arbiter
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_cra_idle = 2'd0,
        e_cra_send = 2'd1,
        e_cra_meta = 2'd2,
        e_cra_wait = 2'd3
    } bp_be_cache_req_arb_state_e;

endpackage

// File: rtl/bp_be_cache_req_arbiter.sv
// rtl/bp_be_cache_req_arbiter.sv - two-requester round-robin arbiter for the D$-to-LCE miss channel
module bp_be_cache_req_arbiter
    import bp_be_pkg::*;
#(
    parameter int req_width_p          = 64,
    parameter int req_metadata_width_p = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [req_width_p-1:0]          req0_i,
    input  logic                            req0_v_i,
    output logic                            req0_ready_o,
    input  logic [req_metadata_width_p-1:0] req0_metadata_i,
    input  logic                            req0_metadata_v_i,
    output logic                            req0_critical_o,
    output logic                            req0_complete_o,

    input  logic [req_width_p-1:0]          req1_i,
    input  logic                            req1_v_i,
    output logic                            req1_ready_o,
    input  logic [req_metadata_width_p-1:0] req1_metadata_i,
    input  logic                            req1_metadata_v_i,
    output logic                            req1_critical_o,
    output logic                            req1_complete_o,

    output logic [req_width_p-1:0]          cache_req_o,
    output logic                            cache_req_v_o,
    input  logic                            cache_req_ready_i,
    output logic [req_metadata_width_p-1:0] cache_req_metadata_o,
    output logic                            cache_req_metadata_v_o,
    input  logic                            cache_req_critical_i,
    input  logic                            cache_req_complete_i,

    output logic                            busy_o,
    output logic                            owner_o
);

    bp_be_cache_req_arb_state_e state, state_n;
    logic owner, owner_n;
    logic prio, prio_n;

    logic in_send, in_meta, in_wait;
    logic own_v, own_md_v;
    logic grant_ready, crit_route, cmp_route;

    assign in_send  = (state == e_cra_send);
    assign in_meta  = (state == e_cra_meta);
    assign in_wait  = (state == e_cra_wait);
    assign own_v    = owner ? req1_v_i : req0_v_i;
    assign own_md_v = owner ? req1_metadata_v_i : req0_metadata_v_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= e_cra_idle;
            owner <= 1'b0;
            prio  <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            prio  <= prio_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        prio_n  = prio;
        case (state)
            e_cra_idle: begin
                if (req0_v_i | req1_v_i) begin
                    owner_n = (req0_v_i & req1_v_i) ? prio : req1_v_i;
                    state_n = e_cra_send;
                end
            end
            e_cra_send: begin
                // A dropped valid is a cancel: fairness pointer is left alone
                if (!own_v) begin
                    state_n = e_cra_idle;
                end else if (cache_req_ready_i) begin
                    state_n = e_cra_meta;
                end
            end
            e_cra_meta: begin
                if (cache_req_complete_i) begin
                    state_n = e_cra_idle;
                    prio_n  = ~owner;
                end else if (own_md_v) begin
                    state_n = e_cra_wait;
                end
            end
            e_cra_wait: begin
                if (cache_req_complete_i) begin
                    state_n = e_cra_idle;
                    prio_n  = ~owner;
                end
            end
            default: state_n = e_cra_idle;
        endcase
    end

    assign cache_req_o            = in_send ? (owner ? req1_i : req0_i) : '0;
    assign cache_req_v_o          = in_send & own_v;
    assign grant_ready            = in_send & own_v & cache_req_ready_i;
    assign req0_ready_o           = grant_ready & ~owner;
    assign req1_ready_o           = grant_ready & owner;

    assign cache_req_metadata_o   = in_meta ? (owner ? req1_metadata_i : req0_metadata_i) : '0;
    assign cache_req_metadata_v_o = in_meta & own_md_v;

    assign crit_route      = (state != e_cra_idle) & cache_req_critical_i;
    assign cmp_route       = (in_meta | in_wait) & cache_req_complete_i;
    assign req0_critical_o = crit_route & ~owner;
    assign req1_critical_o = crit_route & owner;
    assign req0_complete_o = cmp_route & ~owner;
    assign req1_complete_o = cmp_route & owner;

    assign busy_o  = (state != e_cra_idle);
    assign owner_o = owner;

endmodule

// File: tb/tb_bp_be_cache_req_arbiter.sv
// tb/tb_bp_be_cache_req_arbiter.sv - randomized scoreboard bench for bp_be_cache_req_arbiter
module tb_bp_be_cache_req_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] req0_i, req1_i;
    logic        req0_v_i, req1_v_i;
    logic        req0_ready_o, req1_ready_o;
    logic [7:0]  req0_metadata_i, req1_metadata_i;
    logic        req0_metadata_v_i, req1_metadata_v_i;
    logic        req0_critical_o, req1_critical_o;
    logic        req0_complete_o, req1_complete_o;
    logic [63:0] cache_req_o;
    logic        cache_req_v_o;
    logic        cache_req_ready_i;
    logic [7:0]  cache_req_metadata_o;
    logic        cache_req_metadata_v_o;
    logic        cache_req_critical_i;
    logic        cache_req_complete_i;
    logic        busy_o;
    logic        owner_o;

    bp_be_cache_req_arbiter #(.req_width_p(64), .req_metadata_width_p(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req0_i(req0_i), .req0_v_i(req0_v_i), .req0_ready_o(req0_ready_o),
        .req0_metadata_i(req0_metadata_i), .req0_metadata_v_i(req0_metadata_v_i),
        .req0_critical_o(req0_critical_o), .req0_complete_o(req0_complete_o),
        .req1_i(req1_i), .req1_v_i(req1_v_i), .req1_ready_o(req1_ready_o),
        .req1_metadata_i(req1_metadata_i), .req1_metadata_v_i(req1_metadata_v_i),
        .req1_critical_o(req1_critical_o), .req1_complete_o(req1_complete_o),
        .cache_req_o(cache_req_o), .cache_req_v_o(cache_req_v_o),
        .cache_req_ready_i(cache_req_ready_i),
        .cache_req_metadata_o(cache_req_metadata_o),
        .cache_req_metadata_v_o(cache_req_metadata_v_o),
        .cache_req_critical_i(cache_req_critical_i),
        .cache_req_complete_i(cache_req_complete_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          owner;
        logic [63:0] pkt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] md_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         ptr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every LCE handshake must match the next transaction the model predicted
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (cache_req_v_o && cache_req_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fire", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("fire_owner", 64'(owner_o), 64'(e.owner));
                    check("fire_pkt", cache_req_o, e.pkt);
                    check("fire_ready", {62'd0, req1_ready_o, req0_ready_o},
                          e.owner ? 64'd2 : 64'd1);
                end
            end
            if (cache_req_metadata_v_o) begin
                if (md_q.size() == 0) begin
                    check("unexpected_meta", 64'd1, 64'd0);
                end else begin
                    logic [7:0] m;
                    m = md_q.pop_front();
                    check("meta_data", 64'(cache_req_metadata_o), 64'(m));
                end
            end
        end
    end

    function automatic bit pick(input bit v0, input bit v1);
        return (v0 && v1) ? ptr : v1;
    endfunction

    task automatic run_txn(input bit v0, input bit v1, input logic [63:0] p0, input logic [63:0] p1,
                           input logic [7:0] m0, input logic [7:0] m1,
                           input bit with_md, input bit crit, input int delay);
        bit w;
        w = pick(v0, v1);
        req0_i = p0; req1_i = p1;
        req0_metadata_i = m0; req1_metadata_i = m1;
        req0_v_i = v0; req1_v_i = v1;
        exp_q.push_back('{owner: w, pkt: (w ? p1 : p0)});
        @(posedge clk_i); #1;
        repeat (delay) begin
            @(negedge clk_i);
            check("stall_v", 64'(cache_req_v_o), 64'd1);
            check("stall_ready", {62'd0, req1_ready_o, req0_ready_o}, 64'd0);
            @(posedge clk_i); #1;
        end
        cache_req_ready_i = 1'b1;
        @(negedge clk_i);
        check("grant_owner", 64'(owner_o), 64'(w));
        @(posedge clk_i); #1;
        cache_req_ready_i = 1'b0;
        if (w) req1_v_i = 1'b0; else req0_v_i = 1'b0;
        if (with_md) begin
            md_q.push_back(w ? m1 : m0);
            if (w) req1_metadata_v_i = 1'b1; else req0_metadata_v_i = 1'b1;
            @(posedge clk_i); #1;
            req0_metadata_v_i = 1'b0; req1_metadata_v_i = 1'b0;
        end
        if (crit) begin
            cache_req_critical_i = 1'b1;
            @(negedge clk_i);
            check("critical_route", {62'd0, req1_critical_o, req0_critical_o}, w ? 64'd2 : 64'd1);
            @(posedge clk_i); #1;
            cache_req_critical_i = 1'b0;
        end
        cache_req_complete_i = 1'b1;
        @(negedge clk_i);
        check("complete_route", {62'd0, req1_complete_o, req0_complete_o}, w ? 64'd2 : 64'd1);
        @(posedge clk_i); #1;
        cache_req_complete_i = 1'b0;
        req0_v_i = 1'b0; req1_v_i = 1'b0;
        ptr = ~w;
        @(negedge clk_i);
        check("idle_after_complete", 64'(busy_o), 64'd0);
    endtask

    task automatic cancel_txn(input bit v0, input bit v1);
        bit w;
        logic [63:0] p;
        w = pick(v0, v1);
        req0_i = {$urandom, $urandom}; req1_i = {$urandom, $urandom};
        p = w ? req1_i : req0_i;
        req0_v_i = v0; req1_v_i = v1;
        req0_metadata_v_i = 1'b1; req1_metadata_v_i = 1'b1;
        @(posedge clk_i); #1;
        repeat (5) begin
            @(negedge clk_i);
            check("cancel_hold_v", 64'(cache_req_v_o), 64'd1);
            check("cancel_hold_pkt", cache_req_o, p);
            check("cancel_no_ready", {62'd0, req1_ready_o, req0_ready_o}, 64'd0);
            check("early_meta_ignored", 64'(cache_req_metadata_v_o), 64'd0);
            @(posedge clk_i); #1;
        end
        req0_v_i = 1'b0; req1_v_i = 1'b0;
        req0_metadata_v_i = 1'b0; req1_metadata_v_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("cancel_idle", 64'(busy_o), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {cache_req_o, 8'd0}, 72'd0);
        check({name, "_ctl"},
              {52'd0, cache_req_metadata_o, req0_ready_o, req1_ready_o, cache_req_v_o,
               cache_req_metadata_v_o, req0_critical_o, req1_critical_o, req0_complete_o,
               req1_complete_o, busy_o, owner_o}, 64'd0);
    endtask

    initial begin
        reset_i = 1'b1;
        req0_i = '0; req1_i = '0; req0_v_i = 0; req1_v_i = 0;
        req0_metadata_i = '0; req1_metadata_i = '0;
        req0_metadata_v_i = 0; req1_metadata_v_i = 0;
        cache_req_ready_i = 0; cache_req_critical_i = 0; cache_req_complete_i = 0;
        cache_req_critical_i = 1'b1; cache_req_complete_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset_outputs");
        cache_req_critical_i = 1'b0; cache_req_complete_i = 1'b0;
        reset_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_busy", 64'(busy_o), 64'd0);

        // Single requester, known packet and metadata
        run_txn(1, 0, 64'hA5, 64'h0, 8'h3, 8'h0, 1, 0, 0);

        // Contention: pointer now favours req1, then req0
        run_txn(1, 1, 64'h1111, 64'h2222, 8'h11, 8'h22, 1, 1, 0);
        run_txn(1, 1, 64'h3333, 64'h4444, 8'h33, 8'h44, 1, 0, 1);
        run_txn(1, 1, 64'h5555, 64'h6666, 8'h55, 8'h66, 0, 1, 0);

        // Stall then cancel; pointer must not move
        cancel_txn(1, 1);
        run_txn(1, 1, 64'h7777, 64'h8888, 8'h77, 8'h88, 1, 0, 0);

        // Critical with owner 1, complete in META without metadata
        run_txn(0, 1, 64'h0, 64'h9999, 8'h0, 8'h99, 0, 1, 2);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) begin
                cancel_txn(r[0], r[1]);
            end else begin
                run_txn(r[0], r[1], {$urandom, $urandom}, {$urandom, $urandom},
                        8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                        $urandom_range(0, 3));
            end
        end

        // Asynchronous reset while waiting for completion
        req0_i = 64'hDEAD; req1_i = 64'hBEEF; req0_metadata_i = 8'h5A; req1_metadata_i = 8'hA5;
        req0_v_i = 1'b1; req1_v_i = 1'b1;
        exp_q.push_back('{owner: ptr, pkt: (ptr ? 64'hBEEF : 64'hDEAD)});
        md_q.push_back(ptr ? 8'hA5 : 8'h5A);
        @(posedge clk_i); #1;
        cache_req_ready_i = 1'b1;
        @(posedge clk_i); #1;
        cache_req_ready_i = 1'b0;
        req0_v_i = 1'b0; req1_v_i = 1'b0;
        req0_metadata_v_i = 1'b1; req1_metadata_v_i = 1'b1;
        @(posedge clk_i); #1;
        req0_metadata_v_i = 1'b0; req1_metadata_v_i = 1'b0;
        cache_req_critical_i = 1'b1;
        #2;
        check("wait_busy", 64'(busy_o), 64'd1);
        reset_i = 1'b1;
        #1;
        check_all_zero("async_reset");
        cache_req_critical_i = 1'b0;
        ptr = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        cache_req_complete_i = 1'b1;
        @(negedge clk_i);
        check("stray_complete", {61'd0, req1_complete_o, req0_complete_o, busy_o}, 64'd0);
        @(posedge clk_i); #1;
        cache_req_complete_i = 1'b0;
        @(negedge clk_i);
        check("stray_idle", 64'(busy_o), 64'd0);

        // Pointer restarts at 0 after reset
        run_txn(1, 1, 64'hCAFE, 64'hF00D, 8'h01, 8'h02, 1, 1, 1);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("md_q_drained", 64'(md_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_be_cache_req_arbiter.md
Name: bp_be_cache_req_arbiter

Overview:
Shares the single backend D$-to-LCE miss-request channel between two requesters: requester 0 is the D$ miss path and requester 1 is the page-table walker / uncached path.
- Sequences one complete transaction at a time: request, then metadata, then critical and complete notifications routed back to the owner.
- Round-robin fairness between the two requesters.
- Sits between the calculator's memory pipes and the LCE-facing cache_req ports of the backend top.

Parameters:
req_width_p, 64, width of a packed D$ cache request packet
req_metadata_width_p, 8, width of a packed cache request metadata packet

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
req0_i  in  req_width_p  requester 0 request packet
req0_v_i  in  1  requester 0 request valid
req0_ready_o  out  1  requester 0 request accepted
req0_metadata_i  in  req_metadata_width_p  requester 0 metadata
req0_metadata_v_i  in  1  requester 0 metadata valid
req0_critical_o  out  1  critical data returned to requester 0
req0_complete_o  out  1  transaction complete for requester 0
req1_i, req1_v_i, req1_ready_o, req1_metadata_i, req1_metadata_v_i, req1_critical_o, req1_complete_o  same widths and directions as above, for requester 1
cache_req_o  out  req_width_p  request to LCE
cache_req_v_o  out  1  request valid to LCE
cache_req_ready_i  in  1  LCE ready
cache_req_metadata_o  out  req_metadata_width_p  metadata to LCE
cache_req_metadata_v_o  out  1  metadata valid to LCE
cache_req_critical_i  in  1  LCE critical data returned
cache_req_complete_i  in  1  LCE transaction complete
busy_o  out  1  state != IDLE
owner_o  out  1  current or last owner index

Behaviour:
Clocking and reset:
- Single clock clk_i. reset_i is asynchronous and active-high.
- On reset: state=IDLE, owner=0, priority pointer=0. All _v_o, ready, critical, complete and busy outputs are 0. cache_req_o and cache_req_metadata_o are 0.
- Reset asserted mid-transaction abandons the transaction; nothing is replayed.

State machine: IDLE, SEND, META, WAIT.
- IDLE:
  - If exactly one reqN_v_i is high, latch owner=N.
  - If both are high, latch owner=priority pointer.
  - Go to SEND on the next edge.
  - Grant latency is 1 cycle; nothing is driven to the LCE while in IDLE.
- SEND:
  - cache_req_o = owner's packet; cache_req_v_o = owner's req_v_i.
  - req<owner>_ready_o = cache_req_ready_i & req<owner>_v_i. The non-owner's ready is always 0.
  - On fire (v & ready), go to META.
  - If the owner drops v before fire (flush or cancel), go to IDLE; the priority pointer is unchanged.
- META:
  - cache_req_metadata_o = owner's metadata; cache_req_metadata_v_o = owner's metadata_v_i, passed through combinationally.
  - Go to WAIT in the cycle metadata_v is high.
  - Metadata presented before fire is ignored.
- WAIT: wait for cache_req_complete_i.
- Critical and complete routing:
  - cache_req_critical_i routes to req<owner>_critical_o in any non-IDLE state; it is 0 for the non-owner.
  - cache_req_complete_i routes to req<owner>_complete_o in META or WAIT.
  - On complete: go to IDLE, set priority pointer = ~owner.
  - Complete in META (metadata not yet sent, e.g. an uncached miss that needs none) is legal and returns to IDLE.
  - Complete or critical received in IDLE is dropped.
- Timing:
  - Back-to-back transactions: at least one IDLE cycle between complete and the next SEND.
  - No combinational path from cache_req_ready_i to any *_v_o output.
- Starvation bound: a continuously requesting requester is granted within one other transaction.

Decomposition:
- bp_be_pkg: state enum bp_be_cache_req_arb_state_e with values e_cra_idle, e_cra_send, e_cra_meta, e_cra_wait.
- Packet widths come from the existing cache service widths macro at instantiation.
- No sub-module: the round-robin pointer is one flop and the output muxing is a 2:1 select on owner.

Test Plan:
- Reset, then only req0 valid with packet 0xA5 → SEND next cycle; cache_req_o=0xA5, v=1; with ready=1, req0_ready_o=1 in that cycle; metadata 0x3 forwarded in META; complete → req0_complete_o=1, state IDLE, pointer=1.
- req0 and req1 valid together from reset → req0 served first; after its complete, req1 is granted (owner_o=1) while req0 is still valid; a third transaction goes to req0 again.
- Owner in SEND with cache_req_ready_i=0 for 5 cycles → cache_req_v_o held, ready_o=0, packet stable; then the owner drops v → IDLE, pointer unchanged, no LCE fire.
- Critical pulse in WAIT with owner=1 → req1_critical_o=1, req0_critical_o=0; complete in META with no metadata → IDLE, req1_complete_o=1.
- Assert reset_i asynchronously mid-WAIT → all outputs 0 immediately; state IDLE, owner 0; a stray complete after reset release is ignored.
